// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared types and helpers for the LED memory game button path.
//   btn_state_t : selector FSM states (IDLE, HELD, BLOCKED)
//   NUM_BUTTONS : number of physical push buttons
//   onehot4     : 2-bit index -> 4-bit one-hot vector
//   lowest4     : index of the lowest set bit of a 4-bit vector (bit 0 wins)
// -----------------------------------------------------------------------------
package game_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HELD    = 2'd1,
    BLOCKED = 2'd2
  } btn_state_t;

  localparam int NUM_BUTTONS = 4;

  function automatic logic [3:0] onehot4(input logic [1:0] sel);
    logic [3:0] v;
    v      = 4'b0000;
    v[sel] = 1'b1;
    return v;
  endfunction

  // Priority encoder: bit 0 has the highest priority. Callers only use the
  // result when at least one bit is set.
  function automatic logic [1:0] lowest4(input logic [3:0] v);
    logic [1:0] idx;
    if (v[0]) begin
      idx = 2'd0;
    end else if (v[1]) begin
      idx = 2'd1;
    end else if (v[2]) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// -----------------------------------------------------------------------------
// debounce_bit
// One raw button bit: 2-FF synchronizer followed by a counter debouncer.
// A level change is accepted only after DEBOUNCE_CYCLES consecutive cycles of
// disagreement between the synchronized input and the accepted level.
//   clock  : system clock, rising edge
//   reset  : asynchronous, active-high
//   in     : raw asynchronous button level (1 = pressed)
//   stable : debounced level
// -----------------------------------------------------------------------------
module debounce_bit
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic clock,
  input  logic reset,
  input  logic in,
  output logic stable
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic [CW-1:0] r_cnt;

  // Two-flop synchronizer for the asynchronous raw level.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= in;
      r_sync2 <= r_sync1;
    end
  end

  // Mismatch run-length counter; any agreeing cycle restarts the count, so the
  // counter clears at terminal count and never wraps.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else if (r_sync2 == r_stable) begin
      r_cnt    <= '0;
    end else if (r_cnt == TERM) begin
      r_stable <= ~r_stable;
      r_cnt    <= '0;
    end else begin
      r_cnt    <= r_cnt + CW'(1);
    end
  end

  assign stable = r_stable;

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// Debounces four raw push buttons and lets exactly one button win per press
// cycle. The winner is presented as a one-hot level while held and announced
// by a one-cycle strobe when accepted.
//   clock       : system clock, rising edge
//   reset       : asynchronous, active-high
//   rawButton   : raw bouncing button levels (1 = pressed)
//   buttonOut   : one-hot level of the accepted button, or 0
//   buttonPulse : one-hot one-cycle strobe on acceptance, else 0
//   anyPress    : OR of buttonOut
// -----------------------------------------------------------------------------
module button_conditioner
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] rawButton,
  output logic [3:0] buttonOut,
  output logic [3:0] buttonPulse,
  output logic       anyPress
);

  logic [NUM_BUTTONS-1:0] w_stable;
  logic [1:0]             w_first;

  btn_state_t             r_state;
  logic [1:0]             r_sel;
  logic [NUM_BUTTONS-1:0] r_out;
  logic [NUM_BUTTONS-1:0] r_pulse;
  logic                   r_any;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_db
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clock (clock),
      .reset (reset),
      .in    (rawButton[i]),
      .stable(w_stable[i])
    );
  end

  assign w_first = lowest4(w_stable);

  // Selector FSM with registered outputs. The winner is latched on entry to
  // HELD; losing its level while anything else is down parks in BLOCKED so a
  // button held across the hand-over never generates a pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_sel   <= 2'd0;
      r_out   <= 4'b0000;
      r_pulse <= 4'b0000;
      r_any   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_stable != 4'b0000) begin
            r_sel   <= w_first;
            r_pulse <= onehot4(w_first);
            r_out   <= onehot4(w_first);
            r_any   <= 1'b1;
            r_state <= HELD;
          end else begin
            r_pulse <= 4'b0000;
            r_out   <= 4'b0000;
            r_any   <= 1'b0;
            r_state <= IDLE;
          end
        end
        HELD: begin
          r_pulse <= 4'b0000;
          if (!w_stable[r_sel]) begin
            r_out   <= 4'b0000;
            r_any   <= 1'b0;
            r_state <= (w_stable == 4'b0000) ? IDLE : BLOCKED;
          end else begin
            r_out   <= onehot4(r_sel);
            r_any   <= 1'b1;
            r_state <= HELD;
          end
        end
        BLOCKED: begin
          r_pulse <= 4'b0000;
          r_out   <= 4'b0000;
          r_any   <= 1'b0;
          if (w_stable == 4'b0000) begin
            r_state <= IDLE;
          end else begin
            r_state <= BLOCKED;
          end
        end
        default: begin
          // Unreachable encoding: recover to a quiet IDLE.
          r_pulse <= 4'b0000;
          r_out   <= 4'b0000;
          r_any   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign buttonOut   = r_out;
  assign buttonPulse = r_pulse;
  assign anyPress    = r_any;

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

  localparam int D = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] rawButton = 4'b0000;
  logic [3:0] buttonOut;
  logic [3:0] buttonPulse;
  logic       anyPress;

  always #5 clock = ~clock;

  button_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clock      (clock),
    .reset      (reset),
    .rawButton  (rawButton),
    .buttonOut  (buttonOut),
    .buttonPulse(buttonPulse),
    .anyPress   (anyPress)
  );

  // ---------------- behavioural reference model ----------------
  // samp[j] is the raw value sampled j edges ago (samp[0] = this edge).
  // A bit's debounced level flips once the samples taken 2..D+1 edges ago
  // all disagree with it (two edges of synchronizer delay, D-long window).
  logic [3:0] samp [0:D+1];
  logic [3:0] m_stable;
  int         m_held;
  bit         m_blocked;
  logic [3:0] e_out;
  logic [3:0] e_pulse;
  logic       e_any;
  int         edge_n = 0;

  task automatic model_clear();
    for (int j = 0; j <= D + 1; j++) samp[j] = 4'b0000;
    m_stable  = 4'b0000;
    m_held    = -1;
    m_blocked = 1'b0;
    e_out     = 4'b0000;
    e_pulse   = 4'b0000;
    e_any     = 1'b0;
  endtask

  initial begin : model
    model_clear();
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        model_clear();
      end else begin
        edge_n++;
        e_pulse = 4'b0000;
        if (m_held >= 0) begin
          if (!m_stable[m_held]) begin
            m_held    = -1;
            m_blocked = (m_stable != 4'b0000);
          end
        end else if (m_blocked) begin
          if (m_stable == 4'b0000) m_blocked = 1'b0;
        end else if (m_stable != 4'b0000) begin
          for (int b = 3; b >= 0; b--) if (m_stable[b]) m_held = b;
          e_pulse = 4'b0001 << m_held;
        end
        e_out = (m_held >= 0) ? (4'b0001 << m_held) : 4'b0000;
        e_any = (e_out != 4'b0000);
        for (int j = D + 1; j > 0; j--) samp[j] = samp[j-1];
        samp[0] = rawButton;
        for (int b = 0; b < 4; b++) begin
          bit all_diff;
          all_diff = 1'b1;
          for (int j = 2; j <= D + 1; j++) if (samp[j][b] == m_stable[b]) all_diff = 1'b0;
          if (all_diff) m_stable[b] = ~m_stable[b];
        end
      end
    end
  end

  // ---------------- checking ----------------
  int         n_assert = 0;
  int         n_fail = 0;
  int         pulse_cnt = 0;
  int         last_pulse_edge = -1;
  logic [3:0] last_pulse_val = 4'b0000;
  int         fall_edge = -1;
  logic [3:0] prev_out = 4'b0000;
  int         min_gap = 1000;

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (edge %0d)", nm, act, exp, edge_n);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", nm, act, exp, edge_n);
    end
  endtask

  // One cycle: compare against the model on the falling edge, log pulse and
  // release events, then drive the next raw value.
  task automatic tick(input logic [3:0] nxt);
    @(negedge clock);
    chk("buttonOut", buttonOut, e_out);
    chk("buttonPulse", buttonPulse, e_pulse);
    chk("anyPress", {3'b000, anyPress}, {3'b000, e_any});
    if (buttonPulse != 4'b0000) begin
      if (last_pulse_edge >= 0 && (edge_n - last_pulse_edge) < min_gap)
        min_gap = edge_n - last_pulse_edge;
      pulse_cnt++;
      last_pulse_edge = edge_n;
      last_pulse_val  = buttonPulse;
    end
    if (prev_out != 4'b0000 && buttonOut == 4'b0000) fall_edge = edge_n;
    prev_out  = buttonOut;
    rawButton = nxt;
  endtask

  task automatic hold(input logic [3:0] v, input int n);
    for (int i = 0; i < n; i++) tick(v);
  endtask

  initial begin : stim
    int k;
    int p0;
    logic [3:0] v;
    int n;

    // Reset state
    hold(4'b0000, 3);
    chk("reset_buttonOut", buttonOut, 4'b0000);
    chk("reset_buttonPulse", buttonPulse, 4'b0000);
    chk("reset_anyPress", {3'b000, anyPress}, 4'b0000);
    reset = 1'b0;
    hold(4'b0000, 3);

    // Clean press of bit 2
    p0 = pulse_cnt;
    tick(4'b0100);
    k = edge_n + 1;
    hold(4'b0100, 19);
    chki("clean_pulse_edge", last_pulse_edge, k + 6);
    chk("clean_pulse_val", last_pulse_val, 4'b0100);
    chki("clean_pulse_count", pulse_cnt, p0 + 1);
    chk("clean_held_out", buttonOut, 4'b0100);
    tick(4'b0000);
    k = edge_n + 1;
    hold(4'b0000, 11);
    chki("clean_release_edge", fall_edge, k + 6);

    // Bounce on bit 1, then a 3-cycle glitch on bit 0
    p0 = pulse_cnt;
    tick(4'b0010); tick(4'b0000); tick(4'b0010); tick(4'b0010); tick(4'b0000);
    tick(4'b0010);
    k = edge_n + 1;
    hold(4'b0010, 14);
    chki("bounce_pulse_count", pulse_cnt, p0 + 1);
    chki("bounce_pulse_edge", last_pulse_edge, k + 6);
    chk("bounce_pulse_val", last_pulse_val, 4'b0010);
    hold(4'b0000, 12);
    p0 = pulse_cnt;
    hold(4'b0001, 3);
    hold(4'b0000, 12);
    chki("glitch_no_pulse", pulse_cnt, p0);

    // Simultaneous press of bits 0 and 3
    p0 = pulse_cnt;
    hold(4'b1001, 12);
    chk("simul_pulse_val", last_pulse_val, 4'b0001);
    chk("simul_out", buttonOut, 4'b0001);
    hold(4'b0001, 12);
    chk("simul_release3_out", buttonOut, 4'b0001);
    chki("simul_pulse_count", pulse_cnt, p0 + 1);
    hold(4'b0000, 12);

    // Hand-over: bit 0 held, bit 2 joins, bit 0 leaves
    p0 = pulse_cnt;
    hold(4'b0001, 10);
    hold(4'b0101, 10);
    hold(4'b0100, 12);
    chk("handover_blocked_out", buttonOut, 4'b0000);
    chki("handover_no_pulse", pulse_cnt, p0 + 1);
    hold(4'b0000, 12);
    hold(4'b0100, 12);
    chki("handover_repress_count", pulse_cnt, p0 + 2);
    chk("handover_repress_val", last_pulse_val, 4'b0100);
    hold(4'b0000, 12);

    // Reset in HELD with bit 3 still pressed
    p0 = pulse_cnt;
    hold(4'b1000, 12);
    chk("prereset_out", buttonOut, 4'b1000);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_out", buttonOut, 4'b0000);
    chk("async_reset_any", {3'b000, anyPress}, 4'b0000);
    hold(4'b1000, 2);
    reset = 1'b0;
    k = edge_n + 1;
    hold(4'b1000, 12);
    chki("post_reset_pulse_edge", last_pulse_edge, k + 6);
    chk("post_reset_pulse_val", last_pulse_val, 4'b1000);
    chki("post_reset_pulse_count", pulse_cnt, p0 + 2);
    hold(4'b0000, 12);

    // Back-to-back presses at the minimum spacing
    p0 = pulse_cnt;
    last_pulse_edge = -1;
    min_gap = 1000;
    for (int r = 0; r < 5; r++) begin
      hold(4'b0001, D + 1);
      hold(4'b0000, D + 1);
    end
    hold(4'b0000, 12);
    chki("spacing_count", pulse_cnt, p0 + 5);
    chki("spacing_gap", min_gap, 2 * (D + 1));

    // Randomized stimulus against the model
    for (int r = 0; r < 300; r++) begin
      v = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) v = 4'b0000;
      n = int'($urandom_range(1, 12));
      hold(v, n);
    end
    hold(4'b0000, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
